// File: rtl/audio_i2s_tx.sv
// I2S transmitter for 16-bit stereo samples at 48 kHz. MCLK, SCLK and LRCK are clock-enable
// events derived from a fractional accumulator, so everything stays in the clk_74a domain.
module audio_i2s_tx #(
   parameter int unsigned ACC_INC      = 245760,
   parameter int unsigned ACC_MOD      = 742500,
   parameter int unsigned SAMPLE_WIDTH = 16
) (
   input  logic                    clk_74a,
   input  logic                    reset,
   input  logic                    sample_valid,
   output logic                    sample_ready,
   input  logic [SAMPLE_WIDTH-1:0] sample_left,
   input  logic [SAMPLE_WIDTH-1:0] sample_right,
   output logic                    audio_mclk,
   output logic                    audio_lrck,
   output logic                    audio_dac,
   output logic                    frame_tick,
   output logic                    underrun
);

   localparam int unsigned AccW = 22;
   localparam logic [AccW-1:0] AccInc = AccW'(ACC_INC);
   localparam logic [AccW-1:0] AccMod = AccW'(ACC_MOD);

   logic [AccW-1:0]         acc_q, acc_d;
   logic                    mclk_q, mclk_d;
   logic [1:0]              div_q, div_d;
   logic [5:0]              cnt_q, cnt_d;
   logic                    lrck_q, lrck_d;
   logic                    dac_q, dac_d;
   logic                    buf_full_q, buf_full_d;
   logic [SAMPLE_WIDTH-1:0] buf_l_q, buf_l_d;
   logic [SAMPLE_WIDTH-1:0] buf_r_q, buf_r_d;
   logic [SAMPLE_WIDTH-1:0] sh_l_q, sh_l_d;
   logic [SAMPLE_WIDTH-1:0] sh_r_q, sh_r_d;
   logic                    tick_q, tick_d;
   logic                    under_q, under_d;

   logic                    mclk_tog;
   logic                    mclk_rise;
   logic                    sclk_fall;
   logic                    frame_load;
   logic                    accept;
   logic [5:0]              c_next;
   logic [4:0]              bit_pos;
   logic [SAMPLE_WIDTH-1:0] word;
   logic [SAMPLE_WIDTH-1:0] word_shift;

   always_comb begin
      mclk_tog   = (acc_q >= AccMod);
      mclk_rise  = mclk_tog && !mclk_q;
      sclk_fall  = mclk_rise && (div_q == 2'd3);
      c_next     = cnt_q + 6'd1;
      bit_pos    = c_next[4:0];
      frame_load = sclk_fall && (c_next == 6'd0);
      accept     = sample_valid && !buf_full_q;
      word       = c_next[5] ? sh_r_q : sh_l_q;
      // Bring bit (SAMPLE_WIDTH - bit_pos) up to the MSB position.
      word_shift = word << (bit_pos - 5'd1);
   end

   always_comb begin
      acc_d      = mclk_tog ? (acc_q - AccMod + AccInc) : (acc_q + AccInc);
      mclk_d     = mclk_q ^ mclk_tog;
      div_d      = div_q + {1'b0, mclk_rise};
      cnt_d      = cnt_q;
      lrck_d     = lrck_q;
      dac_d      = dac_q;
      buf_full_d = buf_full_q;
      buf_l_d    = buf_l_q;
      buf_r_d    = buf_r_q;
      sh_l_d     = sh_l_q;
      sh_r_d     = sh_r_q;
      tick_d     = frame_load;
      under_d    = frame_load && !buf_full_q;

      if (sclk_fall) begin
         cnt_d  = c_next;
         lrck_d = c_next[5];
         // One-SCLK delay after the LRCK edge, then MSB first, then zero padding.
         if ((bit_pos != 5'd0) && (32'(bit_pos) <= SAMPLE_WIDTH)) begin
            dac_d = word_shift[SAMPLE_WIDTH-1];
         end else begin
            dac_d = 1'b0;
         end
      end

      if (frame_load) begin
         if (buf_full_q) begin
            sh_l_d     = buf_l_q;
            sh_r_d     = buf_r_q;
            buf_full_d = 1'b0;
         end else begin
            sh_l_d = '0;
            sh_r_d = '0;
         end
      end

      // ready is low while full, so an accept never collides with the load's consume.
      if (accept) begin
         buf_l_d    = sample_left;
         buf_r_d    = sample_right;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         acc_q      <= '0;
         mclk_q     <= 1'b0;
         div_q      <= 2'd0;
         cnt_q      <= 6'd63;
         lrck_q     <= 1'b0;
         dac_q      <= 1'b0;
         buf_full_q <= 1'b0;
         buf_l_q    <= '0;
         buf_r_q    <= '0;
         sh_l_q     <= '0;
         sh_r_q     <= '0;
         tick_q     <= 1'b0;
         under_q    <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         mclk_q     <= mclk_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         lrck_q     <= lrck_d;
         dac_q      <= dac_d;
         buf_full_q <= buf_full_d;
         buf_l_q    <= buf_l_d;
         buf_r_q    <= buf_r_d;
         sh_l_q     <= sh_l_d;
         sh_r_q     <= sh_r_d;
         tick_q     <= tick_d;
         under_q    <= under_d;
      end
   end

   assign sample_ready = !buf_full_q;
   assign audio_mclk   = mclk_q;
   assign audio_lrck   = lrck_q;
   assign audio_dac    = dac_q;
   assign frame_tick   = tick_q;
   assign underrun     = under_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: reset values, frame bit patterns, clock rates, handshake
// timing against frame loads, and asynchronous reset in mid-frame.
module tb_audio_i2s_tx;

   localparam int unsigned AccInc = 245760;
   localparam int unsigned AccMod = 742500;

   logic        clk_74a = 1'b0;
   logic        reset;
   logic        sample_valid;
   logic        sample_ready;
   logic [15:0] sample_left;
   logic [15:0] sample_right;
   logic        audio_mclk;
   logic        audio_lrck;
   logic        audio_dac;
   logic        frame_tick;
   logic        underrun;

   always #5 clk_74a = ~clk_74a;

   audio_i2s_tx u_dut (
      .clk_74a      (clk_74a),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_left  (sample_left),
      .sample_right (sample_right),
      .audio_mclk   (audio_mclk),
      .audio_lrck   (audio_lrck),
      .audio_dac    (audio_dac),
      .frame_tick   (frame_tick),
      .underrun     (underrun)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bench-side model of the accumulator, frame position and expected sample stream.
   int unsigned acc_m;
   logic        mclk_prev;
   int          rise_cnt;
   int          pos;
   logic [31:0] cur_w;
   logic [31:0] exp_q[$];
   int          tog_cnt = 0, sf_cnt = 0, ft_cnt = 0, ur_cnt = 0, ones_cnt = 0, nr_cnt = 0;
   int          sb_err = 0;
   logic        last_lrck, last_dac;
   logic        sf, ft_s, ur_s, lrck_s, dac_s;

   task automatic model_reset();
      acc_m     = 0;
      mclk_prev = 1'b0;
      rise_cnt  = 0;
      pos       = 63;
      cur_w     = '0;
      exp_q.delete();
      last_lrck = 1'b0;
      last_dac  = 1'b0;
      sf        = 1'b0;
   endtask

   // Advance one clock; inputs are sampled at the current negedge, outputs at the next one.
   task automatic step();
      logic        pend;
      logic [31:0] pw;
      pend = sample_valid && sample_ready && !reset;
      pw   = {sample_left, sample_right};
      @(posedge clk_74a);
      if (!reset) acc_m = (acc_m >= AccMod) ? acc_m - AccMod + AccInc : acc_m + AccInc;
      @(negedge clk_74a);
      sf = 1'b0;
      if (reset) begin
         model_reset();
         return;
      end
      if (audio_mclk !== mclk_prev) tog_cnt++;
      if (audio_mclk && !mclk_prev) begin
         rise_cnt++;
         sf = (rise_cnt % 4 == 0);
      end
      mclk_prev = audio_mclk;
      if (sf) begin
         logic e_lrck, e_dac, e_ft, e_ur;
         int   p;
         sf_cnt++;
         pos  = (pos + 1) % 64;
         e_ft = (pos == 0);
         e_ur = 1'b0;
         if (pos == 0) begin
            if (exp_q.size() > 0) cur_w = exp_q.pop_front();
            else begin
               cur_w = '0;
               e_ur  = 1'b1;
            end
         end
         e_lrck = (pos >= 32);
         p      = pos % 32;
         if (p >= 1 && p <= 16) e_dac = (pos >= 32) ? cur_w[16-p] : cur_w[32-p];
         else e_dac = 1'b0;
         if ({audio_lrck, audio_dac, frame_tick, underrun} !== {e_lrck, e_dac, e_ft, e_ur})
            sb_err++;
      end else if (frame_tick || underrun || audio_lrck !== last_lrck ||
                   audio_dac !== last_dac) begin
         sb_err++;
      end
      last_lrck = audio_lrck;
      last_dac  = audio_dac;
      if (pend) exp_q.push_back(pw);
      if (frame_tick) ft_cnt++;
      if (underrun) ur_cnt++;
      if (audio_dac) ones_cnt++;
      if (!sample_ready) nr_cnt++;
      ft_s   = frame_tick;
      ur_s   = underrun;
      lrck_s = audio_lrck;
      dac_s  = audio_dac;
   endtask

   task automatic next_sf();
      int n = 0;
      do begin
         step();
         n++;
      end while (!sf && n < 200);
      check_val("sclk_fall_seen", 64'(sf), 64'd1);
   endtask

   // Capture one full frame starting at the next frame load; bit 63 is the load slot.
   task automatic wait_frame(output logic [63:0] dbits, output logic [63:0] lbits,
                             output logic ur0);
      int n = 0;
      do begin
         next_sf();
         n++;
      end while (!ft_s && n < 70);
      check_val("frame_load_seen", 64'(ft_s), 64'd1);
      ur0       = ur_s;
      dbits[63] = dac_s;
      lbits[63] = lrck_s;
      for (int i = 1; i < 64; i++) begin
         next_sf();
         dbits[63-i] = dac_s;
         lbits[63-i] = lrck_s;
      end
   endtask

   initial begin
      logic [63:0] dbits, lbits;
      logic        ur0;
      int          t0, s0, f0, u0, o0, r0, n, k, loads;

      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_left  = '0;
      sample_right = '0;
      model_reset();
      repeat (3) @(negedge clk_74a);

      check_val("rst_mclk", 64'(audio_mclk), 64'd0);
      check_val("rst_lrck", 64'(audio_lrck), 64'd0);
      check_val("rst_dac", 64'(audio_dac), 64'd0);
      check_val("rst_ready", 64'(sample_ready), 64'd1);
      check_val("rst_tick", 64'(frame_tick), 64'd0);
      check_val("rst_underrun", 64'(underrun), 64'd0);

      // Sample offered before the first frame load.
      reset        = 1'b0;
      sample_valid = 1'b1;
      sample_left  = 16'hA5C3;
      sample_right = 16'h8001;
      step();
      sample_valid = 1'b0;
      sample_left  = 16'hDEAD;
      sample_right = 16'hBEEF;
      check_val("ready_after_accept", 64'(sample_ready), 64'd0);
      wait_frame(dbits, lbits, ur0);
      check_val("frame_a5c3_8001_dac", dbits, 64'h52E18000_40008000);
      check_val("frame_lrck_pattern", lbits, 64'h00000000_FFFFFFFF);
      check_val("frame_a5c3_underrun", 64'(ur0), 64'd0);

      // Idle rate window: one accumulator period is 1/60 of the 742500-cycle budget.
      t0 = tog_cnt; s0 = sf_cnt; f0 = ft_cnt; u0 = ur_cnt; o0 = ones_cnt; r0 = nr_cnt;
      repeat (12375) step();
      check_val("mclk_toggles", 64'(tog_cnt - t0), 64'd4096);
      check_val("sclk_falls", 64'(sf_cnt - s0), 64'd512);
      check_val("frame_ticks", 64'(ft_cnt - f0), 64'd8);
      check_val("idle_underruns", 64'(ur_cnt - u0), 64'd8);
      check_val("idle_dac_ones", 64'(ones_cnt - o0), 64'd0);
      check_val("idle_ready_low", 64'(nr_cnt - r0), 64'd0);
      check_val("scoreboard_idle", 64'(sb_err), 64'd0);

      // Continuous stream with sample_valid held high.
      n = 0;
      do begin
         next_sf();
         n++;
      end while (!ft_s && n < 70);
      u0 = ur_cnt;
      k = 0;
      loads = 0;
      n = 0;
      sample_valid = 1'b1;
      while (loads < 5 && n < 12000) begin
         logic was_ready;
         sample_left  = 16'h0100 + 16'(k);
         sample_right = ~sample_left;
         was_ready    = sample_ready;
         step();
         n++;
         if (was_ready) k++;
         if (ft_s) loads++;
      end
      sample_valid = 1'b0;
      check_val("stream_loads", 64'(loads), 64'd5);
      check_val("stream_accepts", 64'(k), 64'd5);
      check_val("stream_underruns", 64'(ur_cnt - u0), 64'd0);
      check_val("stream_ready_after_load", 64'(sample_ready), 64'd1);
      check_val("scoreboard_stream", 64'(sb_err), 64'd0);

      // Accept landing on the exact cycle of a load with the buffer empty.
      n = 0;
      while (!((acc_m >= AccMod) && !audio_mclk && (rise_cnt % 4 == 3) && pos == 63) &&
             n < 3000) begin
         step();
         n++;
      end
      sample_valid = 1'b1;
      sample_left  = 16'h1234;
      sample_right = 16'hFEDC;
      step();
      sample_valid = 1'b0;
      check_val("coincident_tick", 64'(ft_s), 64'd1);
      check_val("coincident_underrun", 64'(ur_s), 64'd1);
      check_val("coincident_ready", 64'(sample_ready), 64'd0);
      wait_frame(dbits, lbits, ur0);
      check_val("coincident_next_frame", dbits, 64'h091A0000_7F6E0000);
      check_val("coincident_next_underrun", 64'(ur0), 64'd0);

      // Reset in mid-frame with the buffer full.
      next_sf();
      check_val("pre_reset_load", 64'(ft_s), 64'd1);
      sample_valid = 1'b1;
      sample_left  = 16'h7777;
      sample_right = 16'h3333;
      step();
      sample_valid = 1'b0;
      check_val("pre_reset_full", 64'(sample_ready), 64'd0);
      n = 0;
      while (!(audio_lrck && audio_mclk) && n < 2000) begin
         step();
         n++;
      end
      check_val("mid_frame_reached", 64'(audio_lrck && audio_mclk), 64'd1);
      reset = 1'b1;
      #1;
      check_val("async_mclk", 64'(audio_mclk), 64'd0);
      check_val("async_lrck", 64'(audio_lrck), 64'd0);
      check_val("async_dac", 64'(audio_dac), 64'd0);
      check_val("async_ready", 64'(sample_ready), 64'd1);
      check_val("async_tick", 64'(frame_tick), 64'd0);
      check_val("async_underrun", 64'(underrun), 64'd0);
      model_reset();
      sample_valid = 1'b1;
      repeat (3) step();
      check_val("ready_in_reset", 64'(sample_ready), 64'd1);
      sample_valid = 1'b0;
      reset        = 1'b0;
      next_sf();
      check_val("post_reset_tick", 64'(ft_s), 64'd1);
      check_val("post_reset_underrun", 64'(ur_s), 64'd1);
      check_val("post_reset_ready", 64'(sample_ready), 64'd1);
      check_val("scoreboard_final", 64'(sb_err), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
